// File: rtl/sa_ram_rwsp_param.sv
// Parametrised 1R1W SRAM model with a zeroing sweep after reset, a two-stage
// read pipeline, a selectable output-stage read-during-write policy and a collision flag.
module sa_ram_rwsp_param #(
  parameter int DEPTH   = 128,
  parameter int WIDTH   = 11,
  parameter int AW      = 7,
  parameter int RDW_FWD = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  output logic             init_done,
  output logic             collide,
  input  logic [31:0]      pwrbus_ram_pd
);

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [AW-1:0]    init_ptr_r;
  logic [AW-1:0]    ra_d_r;
  logic             rd_pend_r;
  logic [WIDTH-1:0] dout_r;
  logic             dout_vld_r;
  logic             init_done_r;
  logic             collide_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  logic             ready_s;
  logic             wr_ok_s;
  logic             rd_ok_s;
  logic             fwd_s;
  logic [WIDTH-1:0] rd_word_s;
  logic [WIDTH-1:0] rd_data_s;
  logic             unused_s;

  assign unused_s = ^pwrbus_ram_pd;
  assign ready_s  = (state_r == ST_READY);
  // Out-of-range addresses (possible when 2^AW > DEPTH) never touch the array.
  assign wr_ok_s  = ready_s & we & ({1'b0, wa} < DEPTH_W);
  assign rd_ok_s  = ({1'b0, ra_d_r} < DEPTH_W);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: leave INIT on the edge that zeroes the last word
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_ptr_r == LAST_ADDR) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_READY: state_nxt_s = ST_READY;
      default:  state_nxt_s = ST_INIT;
    endcase
  end

  // Stage-2 read word, with optional forwarding of a same-edge write
  always_comb begin
    rd_word_s = {WIDTH{1'b0}};
    if (rd_ok_s) begin
      rd_word_s = mem_r[ra_d_r];
    end else begin
      rd_word_s = {WIDTH{1'b0}};
    end
    fwd_s     = (RDW_FWD != 0) && wr_ok_s && (wa == ra_d_r);
    rd_data_s = fwd_s ? di : rd_word_s;
  end

  // Storage array: sweep writes zero during INIT, port writes in READY
  always_ff @(posedge clk) begin
    if (!ready_s) begin
      mem_r[init_ptr_r] <= {WIDTH{1'b0}};
    end else if (wr_ok_s) begin
      mem_r[wa] <= di;
    end
  end

  // Sweep pointer, read pipeline and registered status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_ptr_r  <= {AW{1'b0}};
      init_done_r <= 1'b0;
      ra_d_r      <= {AW{1'b0}};
      rd_pend_r   <= 1'b0;
      dout_r      <= {WIDTH{1'b0}};
      dout_vld_r  <= 1'b0;
      collide_r   <= 1'b0;
    end else if (!ready_s) begin
      if (init_ptr_r != LAST_ADDR) begin
        init_ptr_r <= init_ptr_r + AW'(1);
      end
      init_done_r <= (init_ptr_r == LAST_ADDR);
      dout_r      <= {WIDTH{1'b0}};
      dout_vld_r  <= 1'b0;
      collide_r   <= 1'b0;
    end else begin
      init_done_r <= 1'b1;
      collide_r   <= re & we & (ra == wa);
      if (re) begin
        ra_d_r    <= ra;
        rd_pend_r <= 1'b1;
      end else if (ore) begin
        rd_pend_r <= 1'b0;
      end
      if (ore) begin
        dout_r     <= rd_data_s;
        dout_vld_r <= rd_pend_r;
      end
    end
  end

  assign dout      = dout_r;
  assign dout_vld  = dout_vld_r;
  assign init_done = init_done_r;
  assign collide   = collide_r;

endmodule

// File: tb/tb_sa_ram_rwsp_param.sv
// Bench for sa_ram_rwsp_param: two instances (old-data and forwarding policies)
// checked by directed scenarios and a random run against an array-based model.
module tb_sa_ram_rwsp_param;

  localparam int D = 128;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [6:0]  ra = 7'd0, wa = 7'd0;
  logic        re = 1'b0, ore = 1'b0, we = 1'b0;
  logic [10:0] di = 11'd0;
  logic [31:0] pwr = 32'hDEAD_BEEF;
  logic [10:0] dout0, dout1;
  logic        vld0, vld1, done0, done1, col0, col1;

  int n_chk = 0;
  int n_pass = 0;

  // behavioural model state
  logic [10:0] m_mem [D];
  logic [6:0]  m_ra_d;
  logic        m_pend, m_vld, m_col, m_done;
  logic [10:0] m_dout0, m_dout1;
  int          m_cnt;

  always #5 clk = ~clk;

  sa_ram_rwsp_param #(.DEPTH(128), .WIDTH(11), .AW(7), .RDW_FWD(0)) dut0 (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout0), .dout_vld(vld0),
    .wa(wa), .we(we), .di(di), .init_done(done0), .collide(col0), .pwrbus_ram_pd(pwr));

  sa_ram_rwsp_param #(.DEPTH(128), .WIDTH(11), .AW(7), .RDW_FWD(1)) dut1 (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout1), .dout_vld(vld1),
    .wa(wa), .we(we), .di(di), .init_done(done1), .collide(col1), .pwrbus_ram_pd(pwr));

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = 11'd0;
    m_ra_d = 7'd0; m_pend = 1'b0; m_vld = 1'b0; m_col = 1'b0; m_done = 1'b0;
    m_dout0 = 11'd0; m_dout1 = 11'd0; m_cnt = 0;
  endtask

  // One rising edge of the specified behaviour, using the inputs held at that edge.
  task automatic model_edge(input bit i_re, input logic [6:0] i_ra, input bit i_ore,
                            input bit i_we, input logic [6:0] i_wa, input logic [10:0] i_di);
    logic [10:0] old;
    if (!m_done) begin
      m_cnt++;
      if (m_cnt == D) m_done = 1'b1;
      m_dout0 = 11'd0; m_dout1 = 11'd0; m_vld = 1'b0; m_col = 1'b0;
    end else begin
      old = m_mem[m_ra_d];
      if (i_ore) begin
        m_dout0 = old;
        m_dout1 = (i_we && i_wa == m_ra_d) ? i_di : old;
        m_vld   = m_pend;
      end
      m_col = i_re && i_we && (i_ra == i_wa);
      if (i_re) m_pend = 1'b1;
      else if (i_ore) m_pend = 1'b0;
      if (i_re) m_ra_d = i_ra;
      if (i_we) m_mem[i_wa] = i_di;
    end
  endtask

  task automatic step(input bit i_re, input logic [6:0] i_ra, input bit i_ore,
                      input bit i_we, input logic [6:0] i_wa, input logic [10:0] i_di);
    re = i_re; ra = i_ra; ore = i_ore; we = i_we; wa = i_wa; di = i_di;
    pwr = $urandom;
    @(posedge clk);
    model_edge(i_re, i_ra, i_ore, i_we, i_wa, i_di);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #3;
    n_chk++; if (dout0 !== 11'd0) $display("FAIL reset_dout: got %h want 000", dout0); else n_pass++;
    n_chk++; if (vld0 !== 1'b0) $display("FAIL reset_vld: got %b want 0", vld0); else n_pass++;
    n_chk++; if (done0 !== 1'b0) $display("FAIL reset_done: got %b want 0", done0); else n_pass++;
    n_chk++; if (col0 !== 1'b0) $display("FAIL reset_collide: got %b want 0", col0); else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    rstn = 1'b1;
    for (int e = 1; e <= D; e++) begin
      // port traffic during the sweep must be ignored
      step(1'b1, 7'd5, 1'b1, (e == 10), 7'd5, 11'h3FF);
      n_chk++;
      if (done0 !== ((e == D) ? 1'b1 : 1'b0))
        $display("FAIL init_done_edge%0d: got %b want %b", e, done0, (e == D));
      else n_pass++;
      if (e == 64) begin
        n_chk++; if (vld0 !== 1'b0 || dout0 !== 11'd0 || col0 !== 1'b0)
          $display("FAIL init_quiet: got dout=%h vld=%b col=%b want 000/0/0", dout0, vld0, col0);
        else n_pass++;
      end
    end
  endtask

  task automatic test_init_drop();
    step(1'b1, 7'd5, 1'b0, 1'b0, 7'd0, 11'd0);
    step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 11'd0);
    n_chk++; if (dout0 !== 11'h000) $display("FAIL init_drop_dout: got %h want 000", dout0); else n_pass++;
    n_chk++; if (vld0 !== 1'b1) $display("FAIL init_drop_vld: got %b want 1", vld0); else n_pass++;
  endtask

  task automatic test_write_read();
    step(1'b0, 7'd0, 1'b0, 1'b1, 7'h7F, 11'h7FF);
    step(1'b1, 7'h7F, 1'b0, 1'b0, 7'd0, 11'd0);
    step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 11'd0);
    n_chk++; if (dout0 !== 11'h7FF || vld0 !== 1'b1)
      $display("FAIL read_7f: got %h/%b want 7ff/1", dout0, vld0); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 7'(i), 1'b0, 1'b0, 7'd0, 11'd0);
      n_chk++; if (dout0 !== 11'h7FF) $display("FAIL hold_%0d: got %h want 7ff", i, dout0); else n_pass++;
    end
  endtask

  task automatic test_stage1_collision();
    step(1'b0, 7'd0, 1'b0, 1'b1, 7'd3, 11'h001);
    step(1'b1, 7'd3, 1'b0, 1'b1, 7'd3, 11'h2AA);
    n_chk++; if (col0 !== 1'b1 || col1 !== 1'b1)
      $display("FAIL s1_collide_hi: got %b%b want 11", col0, col1); else n_pass++;
    step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 11'd0);
    n_chk++; if (dout0 !== 11'h2AA || dout1 !== 11'h2AA)
      $display("FAIL s1_dout: got %h/%h want 2aa/2aa", dout0, dout1); else n_pass++;
    n_chk++; if (col0 !== 1'b0) $display("FAIL s1_collide_lo: got %b want 0", col0); else n_pass++;
  endtask

  task automatic test_stage2_collision();
    step(1'b0, 7'd0, 1'b0, 1'b1, 7'd9, 11'h011);
    step(1'b1, 7'd9, 1'b0, 1'b0, 7'd0, 11'd0);
    step(1'b0, 7'd0, 1'b1, 1'b1, 7'd9, 11'h0F0);
    n_chk++; if (dout0 !== 11'h011) $display("FAIL s2_old: got %h want 011", dout0); else n_pass++;
    n_chk++; if (dout1 !== 11'h0F0) $display("FAIL s2_fwd: got %h want 0f0", dout1); else n_pass++;
    n_chk++; if (col0 !== 1'b0) $display("FAIL s2_no_collide: got %b want 0", col0); else n_pass++;
    step(1'b1, 7'd9, 1'b0, 1'b0, 7'd0, 11'd0);
    step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 11'd0);
    n_chk++; if (dout0 !== 11'h0F0) $display("FAIL s2_written: got %h want 0f0", dout0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_w [16];
    step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 11'd0);
    n_chk++; if (vld0 !== 1'b0) $display("FAIL ore_no_pend: got %b want 0", vld0); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      exp_w[i] = 11'($urandom);
      step(1'b0, 7'd0, 1'b0, 1'b1, 7'(i), exp_w[i]);
    end
    step(1'b1, 7'd0, 1'b0, 1'b0, 7'd0, 11'd0);
    for (int i = 1; i <= 16; i++) begin
      step((i < 16), 7'(i), 1'b1, 1'b0, 7'd0, 11'd0);
      n_chk++; if (dout0 !== exp_w[i-1] || vld0 !== 1'b1)
        $display("FAIL b2b_%0d: got %h/%b want %h/1", i - 1, dout0, vld0, exp_w[i-1]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      step(1'($urandom), 7'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
           7'($urandom_range(0, 15)), 11'($urandom));
      n_chk++;
      if (dout0 !== m_dout0 || dout1 !== m_dout1 || vld0 !== m_vld || vld1 !== m_vld ||
          col0 !== m_col || col1 !== m_col)
        $display("FAIL rand_%0d: got %h %h %b %b %b %b want %h %h %b %b", c, dout0, dout1,
                 vld0, vld1, col0, col1, m_dout0, m_dout1, m_vld, m_col);
      else n_pass++;
    end
  endtask

  task automatic test_midreset();
    step(1'b0, 7'd0, 1'b0, 1'b1, 7'h20, 11'h155);
    step(1'b1, 7'h20, 1'b0, 1'b1, 7'h21, 11'h2AA);
    step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 11'd0);
    n_chk++; if (dout0 !== 11'h155) $display("FAIL pre_reset_dout: got %h want 155", dout0); else n_pass++;
    rstn = 1'b0;
    #2;
    n_chk++; if (dout0 !== 11'd0 || vld0 !== 1'b0 || done0 !== 1'b0 || col0 !== 1'b0)
      $display("FAIL async_reset: got %h/%b/%b/%b want 000/0/0/0", dout0, vld0, done0, col0);
    else n_pass++;
    @(posedge clk); #1;
    model_reset();
    rstn = 1'b1;
    for (int e = 1; e <= D; e++) begin
      step(1'b0, 7'd0, 1'b0, 1'b1, 7'h20, 11'h155);
      if (e >= D - 1) begin
        n_chk++; if (done0 !== ((e == D) ? 1'b1 : 1'b0))
          $display("FAIL resweep_done_%0d: got %b want %b", e, done0, (e == D));
        else n_pass++;
      end
    end
    step(1'b1, 7'd0, 1'b0, 1'b0, 7'd0, 11'd0);
    for (int i = 1; i <= D; i++) begin
      step((i < D), 7'(i), 1'b1, 1'b0, 7'd0, 11'd0);
      n_chk++; if (dout0 !== 11'd0 || dout1 !== 11'd0 || vld0 !== 1'b1)
        $display("FAIL zero_%0d: got %h/%h/%b want 000/000/1", i - 1, dout0, dout1, vld0);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init_drop();
    test_write_read();
    test_stage1_collision();
    test_stage2_collision();
    test_back_to_back();
    test_random();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
